gps_ack_peak_tracker: RTL and testbench
=======================================

// Module: gps_ack_peak_tracker
// PURPOSE
//  Per-channel peak search for the parallel acquisition correlator.
//  Consumes one integrator dump per corr_complete and keeps, for each of NCH channels, the best and second-best
//  magnitude with their code phase and Doppler. On sat-block end it flags detection and drains one result per
//  channel over a valid/ready port. Generalises the fixed 8-ch/16-bit result path; adds side-peak ratio detection.
// PARAMETERS
//  NCH        8     correlator channels
//  INT_W      16    integrator width, unsigned
//  PHASE_W    10    code phase width
//  DOP_W      16    doppler_omega width, signed
//  CODE_LEN   1023  code length in chips, for modulo phase distance
//  EXCL       2     second peak must be > EXCL chips (modulo) from best
//  RATIO_SH   1     detect requires peak-second >= second>>RATIO_SH
// PORTS
//  clk          in   1             system clock
//  rst          in   1             asynchronous, active-low reset
//  corr_valid   in   1             1-cycle pulse; sample all corr inputs this cycle
//  sat_id       in   NCH*6         packed PRN per channel, ch0 in LSBs
//  integ        in   NCH*INT_W     packed integrator values
//  code_phase   in   PHASE_W       code phase of this dump
//  doppler      in   DOP_W         signed doppler_omega of this dump
//  block_done   in   1             1-cycle pulse: sat block complete, start drain
//  thresh       in   INT_W         absolute peak detection threshold
//  res_valid    out  1             result beat valid
//  res_ready    in   1             consumer accepts beat
//  res_ch       out  $clog2(NCH)   channel index of beat
//  res_sat      out  6             PRN latched at first dump of block
//  res_phase    out  PHASE_W       code phase of best
//  res_dop      out  DOP_W         doppler of best
//  res_peak     out  INT_W         best value
//  res_second   out  INT_W         second-best value
//  res_det      out  1             detection flag
//  busy         out  1             high in DRAIN
//  overrun      out  1             sticky: corr_valid/block_done seen in DRAIN
// BEHAVIOUR
//  Reset: all outputs 0; every best/second = 0; phase/dop/sat = 0; state ACCUM.
//  States: ACCUM -> DRAIN on block_done; DRAIN -> ACCUM when beat ch NCH-1 is accepted.
//  ACCUM, corr_valid: per ch, v > best: second <= (dist(old best phase, code_phase) > EXCL) ? best : second;
//   best/phase/dop <= v/code_phase/doppler. Else if v > second and dist(best phase, code_phase) > EXCL: second <= v.
//   Ties never replace: the first occurrence is kept.
//  dist(a,b) = min(|a-b|, CODE_LEN-|a-b|). Wrap-around: phases 0 and 1022 are 1 chip apart.
//  sat_id latched on first corr_valid after entering ACCUM.
//  corr_valid with block_done in the same cycle: the dump is accumulated first, then DRAIN.
//  Drain: res_valid rises the cycle after block_done. Channels are sent 0..NCH-1.
//   A beat completes on res_valid & res_ready. The next channel is presented the following cycle, no bubble.
//   Payload is stable while res_valid & !res_ready.
//  res_det = (peak >= thresh) && (peak - second >= second >> RATIO_SH). Unsigned, INT_W+1 internal, no overflow.
//  After last accept: best/second cleared, res_valid=0, busy=0 next cycle.
//  corr_valid or block_done in DRAIN: ignored, overrun <= 1. overrun is cleared only by reset.
//  Reset mid-drain: immediately back to reset state; a partial drain is not resumed.
// STRUCTURE
//  Package gps_ack_pkg: PRN_W=6, typedef ack_result_t {sat, phase, dop, peak, second, det}, function
//   code_dist(a,b,len).
//  Sub-module gps_ack_peak_cell: one channel's best/second/phase/dop registers + update logic.
//   Generated NCH times.
//  Top: FSM, drain channel counter, output mux, detect compare.
// TESTING
//  1 ch0 dumps 100@ph5, 300@ph200, 250@ph201 -> peak 300 ph200, second 100 (250 excluded); thresh 200 -> det=1.
//  2 Wrap: best 500@ph0, then 400@ph1022 -> second stays 0; 400@ph10 -> second 400; RATIO_SH=1 -> det=0.
//  3 Tie: 300@ph7 then 300@ph50 -> phase 7 kept, second 300.
//  4 NCH=8, res_ready toggled 1/0 -> 8 beats, ch 0..7 in order; payload held while stalled; busy low after ch7.
//  5 corr_valid during DRAIN -> ignored, overrun=1; corr_valid+block_done same cycle -> that dump included.
//  6 rst low mid-drain after ch3 -> all outputs 0; next block reports fresh values from ch0.

Source files
------------

// File: rtl/gps_ack_pkg.sv
// Shared types and helpers for the acquisition peak tracker.
// Provides the result record, the FSM state type and the modulo code-phase distance.
package gps_ack_pkg;

    localparam int PRN_W       = 6;
    localparam int ACK_INT_W   = 16;
    localparam int ACK_PHASE_W = 10;
    localparam int ACK_DOP_W   = 16;

    typedef enum logic {
        ACK_ACCUM = 1'b0,
        ACK_DRAIN = 1'b1
    } ack_state_e;

    typedef struct packed {
        logic [PRN_W-1:0]              sat;
        logic [ACK_PHASE_W-1:0]        phase;
        logic signed [ACK_DOP_W-1:0]   dop;
        logic [ACK_INT_W-1:0]          peak;
        logic [ACK_INT_W-1:0]          second;
        logic                          det;
    } ack_result_t;

    // Circular chip distance; phases 0 and len-1 are one chip apart.
    function automatic int unsigned code_dist(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned len);
        int unsigned d;
        d = (a > b) ? (a - b) : (b - a);
        return (d > (len - d)) ? (len - d) : d;
    endfunction

endpackage

// File: rtl/gps_ack_peak_cell.sv
// One correlator channel: best/second magnitude search with code-phase exclusion zone.
// The PRN is captured on the first dump of each block.
module gps_ack_peak_cell
    import gps_ack_pkg::*;
#(
    parameter int          INT_W    = 16,
    parameter int          PHASE_W  = 10,
    parameter int          DOP_W    = 16,
    parameter int unsigned CODE_LEN = 1023,
    parameter int unsigned EXCL     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               upd,
    input  logic               first,
    input  logic [INT_W-1:0]   v,
    input  logic [PRN_W-1:0]   sat_in,
    input  logic [PHASE_W-1:0] code_phase,
    input  logic [DOP_W-1:0]   doppler,
    output logic [INT_W-1:0]   best,
    output logic [INT_W-1:0]   second,
    output logic [PHASE_W-1:0] phase,
    output logic [DOP_W-1:0]   dop,
    output logic [PRN_W-1:0]   sat
);

    logic [INT_W-1:0]   best_r;
    logic [INT_W-1:0]   second_r;
    logic [PHASE_W-1:0] phase_r;
    logic [DOP_W-1:0]   dop_r;
    logic [PRN_W-1:0]   sat_r;
    logic               far_s;

    // Is this dump outside the exclusion zone around the current best?
    always_comb begin
        far_s = (code_dist(32'(phase_r), 32'(code_phase), CODE_LEN) > EXCL);
    end

    // Peak registers; strict compares so ties keep the earlier dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_r   <= '0;
            second_r <= '0;
            phase_r  <= '0;
            dop_r    <= '0;
            sat_r    <= '0;
        end else if (clr) begin
            best_r   <= '0;
            second_r <= '0;
            phase_r  <= '0;
            dop_r    <= '0;
            sat_r    <= '0;
        end else if (upd) begin
            if (first) begin
                sat_r <= sat_in;
            end
            if (v > best_r) begin
                // An old best next to the new one is the same correlation lobe.
                second_r <= far_s ? best_r : second_r;
                best_r   <= v;
                phase_r  <= code_phase;
                dop_r    <= doppler;
            end else if ((v > second_r) && far_s) begin
                second_r <= v;
            end
        end
    end

    assign best   = best_r;
    assign second = second_r;
    assign phase  = phase_r;
    assign dop    = dop_r;
    assign sat    = sat_r;

endmodule

// File: rtl/gps_ack_peak_tracker.sv
// Parallel acquisition peak tracker: NCH peak cells, block FSM and a valid/ready
// drain that reports one result per channel with side-peak ratio detection.
module gps_ack_peak_tracker
    import gps_ack_pkg::*;
#(
    parameter int          NCH      = 8,
    parameter int          INT_W    = ACK_INT_W,
    parameter int          PHASE_W  = ACK_PHASE_W,
    parameter int          DOP_W    = ACK_DOP_W,
    parameter int unsigned CODE_LEN = 1023,
    parameter int unsigned EXCL     = 2,
    parameter int          RATIO_SH = 1,
    localparam int         CH_W     = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   corr_valid,
    input  logic [NCH*PRN_W-1:0]   sat_id,
    input  logic [NCH*INT_W-1:0]   integ,
    input  logic [PHASE_W-1:0]     code_phase,
    input  logic [DOP_W-1:0]       doppler,
    input  logic                   block_done,
    input  logic [INT_W-1:0]       thresh,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CH_W-1:0]        res_ch,
    output logic [PRN_W-1:0]       res_sat,
    output logic [PHASE_W-1:0]     res_phase,
    output logic [DOP_W-1:0]       res_dop,
    output logic [INT_W-1:0]       res_peak,
    output logic [INT_W-1:0]       res_second,
    output logic                   res_det,
    output logic                   busy,
    output logic                   overrun
);

    ack_state_e         state_r, state_n;
    logic [CH_W-1:0]    ch_r;
    logic               first_r;
    logic               overrun_r;
    logic               upd_s, clr_s, accept_s, ovr_set_s, last_s;
    logic [INT_W:0]     diff_s, half_s;
    ack_result_t        res_s;

    logic [INT_W-1:0]   best_a   [NCH];
    logic [INT_W-1:0]   second_a [NCH];
    logic [PHASE_W-1:0] phase_a  [NCH];
    logic [DOP_W-1:0]   dop_a    [NCH];
    logic [PRN_W-1:0]   sat_a    [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_cell
        gps_ack_peak_cell #(
            .INT_W    (INT_W),
            .PHASE_W  (PHASE_W),
            .DOP_W    (DOP_W),
            .CODE_LEN (CODE_LEN),
            .EXCL     (EXCL)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr_s),
            .upd        (upd_s),
            .first      (first_r),
            .v          (integ[g*INT_W +: INT_W]),
            .sat_in     (sat_id[g*PRN_W +: PRN_W]),
            .code_phase (code_phase),
            .doppler    (doppler),
            .best       (best_a[g]),
            .second     (second_a[g]),
            .phase      (phase_a[g]),
            .dop        (dop_a[g]),
            .sat        (sat_a[g])
        );
    end

    assign last_s = (ch_r == CH_W'(NCH - 1));

    // Block state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ACK_ACCUM;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state and per-cycle controls; a dump coincident with block_done is still taken.
    always_comb begin
        state_n   = state_r;
        upd_s     = 1'b0;
        clr_s     = 1'b0;
        accept_s  = 1'b0;
        ovr_set_s = 1'b0;
        case (state_r)
            ACK_ACCUM: begin
                upd_s = corr_valid;
                if (block_done) begin
                    state_n = ACK_DRAIN;
                end else begin
                    state_n = ACK_ACCUM;
                end
            end
            ACK_DRAIN: begin
                ovr_set_s = corr_valid | block_done;
                accept_s  = res_ready;
                if (res_ready && last_s) begin
                    state_n = ACK_ACCUM;
                    clr_s   = 1'b1;
                end else begin
                    state_n = ACK_DRAIN;
                end
            end
            default: begin
                state_n = ACK_ACCUM;
            end
        endcase
    end

    // Drain channel counter, held at zero while accumulating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_r <= '0;
        end else if (state_r == ACK_ACCUM) begin
            ch_r <= '0;
        end else if (accept_s) begin
            ch_r <= last_s ? '0 : ch_r + CH_W'(1);
        end
    end

    // First-dump flag for PRN capture, re-armed after every completed drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_r <= 1'b1;
        end else if (clr_s) begin
            first_r <= 1'b1;
        end else if (upd_s) begin
            first_r <= 1'b0;
        end
    end

    // Sticky overrun, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= 1'b0;
        end else if (ovr_set_s) begin
            overrun_r <= 1'b1;
        end
    end

    // Result mux and detection; payload forced to zero outside DRAIN.
    always_comb begin
        res_s  = '0;
        diff_s = {1'b0, second_a[ch_r]};
        half_s = {1'b0, second_a[ch_r] >> RATIO_SH};
        if (state_r == ACK_DRAIN) begin
            diff_s       = {1'b0, best_a[ch_r]} - {1'b0, second_a[ch_r]};
            res_s.sat    = sat_a[ch_r];
            res_s.phase  = ACK_PHASE_W'(phase_a[ch_r]);
            res_s.dop    = ACK_DOP_W'(dop_a[ch_r]);
            res_s.peak   = ACK_INT_W'(best_a[ch_r]);
            res_s.second = ACK_INT_W'(second_a[ch_r]);
            res_s.det    = (best_a[ch_r] >= thresh) && (diff_s >= half_s);
        end else begin
            res_s = '0;
        end
    end

    assign res_valid  = (state_r == ACK_DRAIN);
    assign busy       = (state_r == ACK_DRAIN);
    assign res_ch     = (state_r == ACK_DRAIN) ? ch_r : '0;
    assign res_sat    = res_s.sat;
    assign res_phase  = PHASE_W'(res_s.phase);
    assign res_dop    = DOP_W'(res_s.dop);
    assign res_peak   = INT_W'(res_s.peak);
    assign res_second = INT_W'(res_s.second);
    assign res_det    = res_s.det;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_gps_ack_peak_tracker.sv
// Directed bench for gps_ack_peak_tracker: peak/second search, wrap-around exclusion,
// ties, stalled drain, overrun and reset mid-drain.
module tb_gps_ack_peak_tracker;

    localparam int NCH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          corr_valid = 1'b0;
    logic [47:0]   sat_id = '0;
    logic [127:0]  integ = '0;
    logic [9:0]    code_phase = '0;
    logic [15:0]   doppler = '0;
    logic          block_done = 1'b0;
    logic [15:0]   thresh = 16'd100;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [2:0]    res_ch;
    logic [5:0]    res_sat;
    logic [9:0]    res_phase;
    logic [15:0]   res_dop;
    logic [15:0]   res_peak;
    logic [15:0]   res_second;
    logic          res_det;
    logic          busy;
    logic          overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] dv     [NCH];
    logic [31:0] e_peak [NCH];
    logic [31:0] e_sec  [NCH];
    logic [31:0] e_ph   [NCH];
    logic [31:0] e_dop  [NCH];
    logic [31:0] e_sat  [NCH];
    logic [31:0] e_det  [NCH];

    gps_ack_peak_tracker u_dut (
        .clk        (clk),
        .rst        (rst),
        .corr_valid (corr_valid),
        .sat_id     (sat_id),
        .integ      (integ),
        .code_phase (code_phase),
        .doppler    (doppler),
        .block_done (block_done),
        .thresh     (thresh),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ch     (res_ch),
        .res_sat    (res_sat),
        .res_phase  (res_phase),
        .res_dop    (res_dop),
        .res_peak   (res_peak),
        .res_second (res_second),
        .res_det    (res_det),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ch"}, 32'(res_ch), 32'd0);
        chk({tag, "_peak"}, 32'(res_peak), 32'd0);
        chk({tag, "_second"}, 32'(res_second), 32'd0);
        chk({tag, "_phase"}, 32'(res_phase), 32'd0);
        chk({tag, "_dop"}, 32'(res_dop), 32'd0);
        chk({tag, "_sat"}, 32'(res_sat), 32'd0);
        chk({tag, "_det"}, 32'(res_det), 32'd0);
    endtask

    task automatic clr_dv();
        for (int i = 0; i < NCH; i++) dv[i] = 16'd0;
    endtask

    task automatic set_exp(input int ch, input logic [31:0] pk, input logic [31:0] sc,
                           input logic [31:0] ph, input logic [31:0] dp,
                           input logic [31:0] st, input logic [31:0] dt);
        e_peak[ch] = pk; e_sec[ch] = sc; e_ph[ch] = ph;
        e_dop[ch] = dp; e_sat[ch] = st; e_det[ch] = dt;
    endtask

    // Called at posedge+1; presents one dump for one cycle.
    task automatic do_dump(input logic [9:0] ph, input logic [15:0] dop,
                           input int sat_base, input bit bd);
        for (int i = 0; i < NCH; i++) begin
            integ[i*16 +: 16] = dv[i];
            sat_id[i*6 +: 6]  = 6'(sat_base + i);
        end
        code_phase = ph;
        doppler    = dop;
        corr_valid = 1'b1;
        block_done = bd;
        @(posedge clk); #1;
        corr_valid = 1'b0;
        block_done = 1'b0;
    endtask

    // Accept nacc beats, checking every presented cycle (stalled ones included).
    task automatic drain(input int nacc, input bit tog, input bit inject);
        int got;
        bit rdy;
        got = 0;
        rdy = !tog;
        for (int cyc = 0; cyc < 64 && got < nacc; cyc++) begin
            @(negedge clk);
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("res_ch", 32'(res_ch), 32'(got));
            chk($sformatf("peak%0d", got), 32'(res_peak), e_peak[got]);
            chk($sformatf("second%0d", got), 32'(res_second), e_sec[got]);
            chk($sformatf("phase%0d", got), 32'(res_phase), e_ph[got]);
            chk($sformatf("dop%0d", got), 32'(res_dop), e_dop[got]);
            chk($sformatf("sat%0d", got), 32'(res_sat), e_sat[got]);
            chk($sformatf("det%0d", got), 32'(res_det), e_det[got]);
            res_ready = rdy;
            if (inject && cyc == 1) begin
                corr_valid = 1'b1;
                integ      = '1;
            end
            if (inject && cyc == 3) block_done = 1'b1;
            @(posedge clk); #1;
            corr_valid = 1'b0;
            block_done = 1'b0;
            if (rdy) got++;
            if (tog) rdy = !rdy;
        end
        res_ready = 1'b0;
        chk("drain_beats", 32'(got), 32'(nacc));
    endtask

    initial begin
        clr_dv();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("rst");
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Block 1: ch0 basic, ch1 wrap, ch2 tie, ch3 same-cycle block_done, ch4/5 threshold edge.
        clr_dv(); dv[0] = 16'd100; dv[3] = 16'd50; dv[4] = 16'd100; dv[5] = 16'd99;
        do_dump(10'd5, 16'hFF38, 10, 1'b0);
        clr_dv(); dv[0] = 16'd300; dv[3] = 16'd60;
        do_dump(10'd200, 16'd1234, 40, 1'b0);
        clr_dv(); dv[0] = 16'd250;
        do_dump(10'd201, 16'd555, 40, 1'b0);
        clr_dv(); dv[1] = 16'd500;
        do_dump(10'd0, 16'hFC18, 40, 1'b0);
        clr_dv(); dv[1] = 16'd400;
        do_dump(10'd1022, 16'd7, 40, 1'b0);
        clr_dv(); dv[1] = 16'd400;
        do_dump(10'd10, 16'd8, 40, 1'b0);
        clr_dv(); dv[2] = 16'd300;
        do_dump(10'd7, 16'd77, 40, 1'b0);
        clr_dv(); dv[2] = 16'd300;
        do_dump(10'd50, 16'd88, 40, 1'b0);
        chk("pre_done_valid", 32'(res_valid), 32'd0);
        clr_dv(); dv[3] = 16'd70;
        do_dump(10'd300, 16'h8001, 40, 1'b1);
        chk("valid_after_done", 32'(res_valid), 32'd1);
        chk("overrun_pre", 32'(overrun), 32'd0);

        set_exp(0, 300, 100, 200, 16'd1234, 10, 1);
        set_exp(1, 500, 400, 0, 16'hFC18, 11, 0);
        set_exp(2, 300, 300, 7, 16'd77, 12, 0);
        set_exp(3, 70, 60, 300, 16'h8001, 13, 0);
        set_exp(4, 100, 0, 5, 16'hFF38, 14, 1);
        set_exp(5, 99, 0, 5, 16'hFF38, 15, 0);
        set_exp(6, 0, 0, 0, 0, 16, 0);
        set_exp(7, 0, 0, 0, 0, 17, 0);
        drain(8, 1'b1, 1'b1);
        chk("end_valid", 32'(res_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("overrun_set", 32'(overrun), 32'd1);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Block 2: values must start from cleared state; reset after four beats.
        for (int i = 0; i < NCH; i++) begin
            dv[i] = 16'(1000 + i * 10);
            set_exp(i, 32'(1000 + i * 10), 0, 33, 16'd42, 32'(20 + i), 1);
        end
        do_dump(10'd33, 16'd42, 20, 1'b1);
        drain(4, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Block 3: fresh drain from ch0 after the aborted one.
        for (int i = 0; i < NCH; i++) begin
            dv[i] = 16'(200 + i);
            set_exp(i, 32'(200 + i), 0, 400, 16'hFFFB, 32'(30 + i), 1);
        end
        do_dump(10'd400, 16'hFFFB, 30, 1'b1);
        drain(8, 1'b0, 1'b0);
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
